// File: rtl/mfp_ahb_arbiter.sv
// Two-master AHB-lite arbiter: M0 (CPU) has priority, M1 (aux engine) gets the bus on M0 release.
// Define MFP_AHB_ARB_STARVE_EN to add a wait counter that forces a handover to M1 after MAX_WAIT cycles.
module mfp_ahb_arbiter #(
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        M0_HBUSREQ,
  input  logic        M1_HBUSREQ,
  input  logic [31:0] M0_HADDR,
  input  logic [1:0]  M0_HTRANS,
  input  logic        M0_HWRITE,
  input  logic [2:0]  M0_HSIZE,
  input  logic [31:0] M0_HWDATA,
  input  logic [31:0] M1_HADDR,
  input  logic [1:0]  M1_HTRANS,
  input  logic        M1_HWRITE,
  input  logic [2:0]  M1_HSIZE,
  input  logic [31:0] M1_HWDATA,
  input  logic        HREADY,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,
  output logic        M0_HGRANT,
  output logic        M1_HGRANT,
  output logic        HMASTER
);

  localparam logic [1:0] ST_PARK0    = 2'd0;
  localparam logic [1:0] ST_OWN0     = 2'd1;
  localparam logic [1:0] ST_OWN1     = 2'd2;
  localparam logic [1:0] ST_HANDOVER = 2'd3;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

`ifdef MFP_AHB_ARB_STARVE_EN
  localparam bit STARVE_EN = 1'b1;
`else
  localparam bit STARVE_EN = 1'b0;
`endif

  logic [1:0] state_q, state_d;
  logic       downer_q, downer_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       m1_xfer_q, m1_xfer_d;
  logic       hmaster;
  logic       m0_rel, m1_rel, starve_hit, m1_preempt_ok;

  // Grant moves to M1 already in HANDOVER; that cycle's address phase is forced IDLE.
  assign hmaster = (state_q == ST_OWN1) || (state_q == ST_HANDOVER);
  assign m0_rel  = !M0_HBUSREQ && (M0_HTRANS == TR_IDLE);
  assign m1_rel  = !M1_HBUSREQ && (M1_HTRANS == TR_IDLE);

  assign starve_hit = STARVE_EN && (32'(wait_cnt_q) >= MAX_WAIT) &&
                      M1_HBUSREQ && (M0_HTRANS != TR_SEQ);

  // With the starvation guard, M1 keeps the bus until one of its transfers has been accepted.
  assign m1_preempt_ok = M0_HBUSREQ && (M1_HTRANS != TR_SEQ) &&
                         (!STARVE_EN || m1_xfer_q || (M1_HTRANS == TR_NONSEQ));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_PARK0: begin
        if (M0_HBUSREQ)      state_d = ST_OWN0;
        else if (M1_HBUSREQ) state_d = ST_HANDOVER;
      end
      ST_OWN0: begin
        if (m0_rel)          state_d = M1_HBUSREQ ? ST_HANDOVER : ST_PARK0;
        else if (starve_hit) state_d = ST_HANDOVER;
      end
      ST_OWN1: begin
        if (m1_rel)             state_d = M0_HBUSREQ ? ST_OWN0 : ST_PARK0;
        else if (m1_preempt_ok) state_d = ST_OWN0;
      end
      default: state_d = ST_OWN1;
    endcase
    if (!HREADY) state_d = state_q;
  end

  always_comb begin
    downer_d  = HREADY ? hmaster : downer_q;
    m1_xfer_d = m1_xfer_q;
    if (HREADY) m1_xfer_d = (state_q == ST_OWN1) && (m1_xfer_q || M1_HTRANS[1]);
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
`ifdef MFP_AHB_ARB_STARVE_EN
    if (HREADY) begin
      if (state_q == ST_HANDOVER)
        wait_cnt_d = 8'd0;
      else if ((state_q == ST_OWN0) && M1_HBUSREQ && (wait_cnt_q != 8'hFF))
        wait_cnt_d = wait_cnt_q + 8'd1;
    end
`else
    wait_cnt_d = 8'd0;
`endif
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= ST_PARK0;
      downer_q   <= 1'b0;
      wait_cnt_q <= 8'd0;
      m1_xfer_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      downer_q   <= downer_d;
      wait_cnt_q <= wait_cnt_d;
      m1_xfer_q  <= m1_xfer_d;
    end
  end

  always_comb begin
    HADDR  = hmaster ? M1_HADDR  : M0_HADDR;
    HWRITE = hmaster ? M1_HWRITE : M0_HWRITE;
    HSIZE  = hmaster ? M1_HSIZE  : M0_HSIZE;
    HTRANS = hmaster ? M1_HTRANS : M0_HTRANS;
    if ((state_q == ST_PARK0) || (state_q == ST_HANDOVER)) HTRANS = TR_IDLE;
  end

  assign HWDATA    = downer_q ? M1_HWDATA : M0_HWDATA;
  assign M0_HGRANT = !hmaster;
  assign M1_HGRANT = hmaster;
  assign HMASTER   = hmaster;

endmodule

// File: tb/tb_mfp_ahb_arbiter.sv
// Directed bench for mfp_ahb_arbiter (MAX_WAIT = 4); starvation checks follow MFP_AHB_ARB_STARVE_EN.
module tb_mfp_ahb_arbiter;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        M0_HBUSREQ, M1_HBUSREQ;
  logic [31:0] M0_HADDR, M1_HADDR, M0_HWDATA, M1_HWDATA;
  logic [1:0]  M0_HTRANS, M1_HTRANS;
  logic        M0_HWRITE, M1_HWRITE;
  logic [2:0]  M0_HSIZE, M1_HSIZE;
  logic        HREADY;
  logic [31:0] HADDR, HWDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic        M0_HGRANT, M1_HGRANT, HMASTER;

  int total = 0;
  int bad   = 0;

  mfp_ahb_arbiter #(.MAX_WAIT(4)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .M0_HBUSREQ(M0_HBUSREQ), .M1_HBUSREQ(M1_HBUSREQ),
    .M0_HADDR(M0_HADDR), .M0_HTRANS(M0_HTRANS), .M0_HWRITE(M0_HWRITE),
    .M0_HSIZE(M0_HSIZE), .M0_HWDATA(M0_HWDATA),
    .M1_HADDR(M1_HADDR), .M1_HTRANS(M1_HTRANS), .M1_HWRITE(M1_HWRITE),
    .M1_HSIZE(M1_HSIZE), .M1_HWDATA(M1_HWDATA),
    .HREADY(HREADY),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
    .M0_HGRANT(M0_HGRANT), .M1_HGRANT(M1_HGRANT), .HMASTER(HMASTER)
  );

  always #5 HCLK = ~HCLK;

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle_inputs();
    M0_HBUSREQ = 1'b0; M1_HBUSREQ = 1'b0;
    M0_HADDR = '0; M0_HTRANS = 2'b00; M0_HWRITE = 1'b0; M0_HSIZE = 3'b010; M0_HWDATA = '0;
    M1_HADDR = '0; M1_HTRANS = 2'b00; M1_HWRITE = 1'b0; M1_HSIZE = 3'b010; M1_HWDATA = '0;
    HREADY = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    HRESETn = 1'b0;
    #12;
    @(negedge HCLK);
    HRESETn = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    HRESETn = 1'b1;
    #3 HRESETn = 1'b0;
    #1;
    total++; if (M0_HGRANT !== 1'b1) begin bad++; $display("FAIL rst_async_g0 got=%b want=1", M0_HGRANT); end
    total++; if (M1_HGRANT !== 1'b0) begin bad++; $display("FAIL rst_async_g1 got=%b want=0", M1_HGRANT); end
    total++; if (HMASTER !== 1'b0) begin bad++; $display("FAIL rst_async_hmaster got=%b want=0", HMASTER); end
    total++; if (HTRANS !== 2'b00) begin bad++; $display("FAIL rst_async_htrans got=%b want=00", HTRANS); end
    @(negedge HCLK);
    HRESETn = 1'b1;
    for (int i = 0; i < 5; i++) step();
    total++; if (M0_HGRANT !== 1'b1) begin bad++; $display("FAIL idle5_g0 got=%b want=1", M0_HGRANT); end
    total++; if (HMASTER !== 1'b0) begin bad++; $display("FAIL idle5_hmaster got=%b want=0", HMASTER); end
    total++; if (HTRANS !== 2'b00) begin bad++; $display("FAIL idle5_htrans got=%b want=00", HTRANS); end
  endtask

  task automatic test_simul_req();
    do_reset();
    M0_HBUSREQ = 1'b1; M0_HTRANS = 2'b10; M0_HADDR = 32'h1000_0000;
    M1_HBUSREQ = 1'b1; M1_HTRANS = 2'b10; M1_HADDR = 32'h2000_0000;
    #1;
    total++; if (HTRANS !== 2'b00) begin bad++; $display("FAIL park_htrans got=%b want=00", HTRANS); end
    step();
    total++; if (M0_HGRANT !== 1'b1 || M1_HGRANT !== 1'b0) begin bad++;
      $display("FAIL simul_grant got=%b%b want=10", M0_HGRANT, M1_HGRANT); end
    total++; if (HADDR !== 32'h1000_0000) begin bad++; $display("FAIL simul_haddr got=%h want=10000000", HADDR); end
    total++; if (HTRANS !== 2'b10) begin bad++; $display("FAIL simul_htrans got=%b want=10", HTRANS); end
    step();
    total++; if (M1_HGRANT !== 1'b0) begin bad++; $display("FAIL simul_hold_g1 got=%b want=0", M1_HGRANT); end
    M0_HBUSREQ = 1'b0; M0_HTRANS = 2'b00;
    step();
    total++; if (M1_HGRANT !== 1'b1 || M0_HGRANT !== 1'b0) begin bad++;
      $display("FAIL handover_grant got=%b%b want=01", M0_HGRANT, M1_HGRANT); end
    total++; if (HTRANS !== 2'b00) begin bad++; $display("FAIL handover_htrans got=%b want=00", HTRANS); end
    step();
    total++; if (HMASTER !== 1'b1) begin bad++; $display("FAIL own1_hmaster got=%b want=1", HMASTER); end
    total++; if (HTRANS !== 2'b10) begin bad++; $display("FAIL own1_htrans got=%b want=10", HTRANS); end
    total++; if (HADDR !== 32'h2000_0000) begin bad++; $display("FAIL own1_haddr got=%h want=20000000", HADDR); end
    M1_HBUSREQ = 1'b0; M1_HTRANS = 2'b00;
    step();
    total++; if (M0_HGRANT !== 1'b1 || HMASTER !== 1'b0) begin bad++;
      $display("FAIL park_return got g0=%b hm=%b want g0=1 hm=0", M0_HGRANT, HMASTER); end
  endtask

  task automatic test_burst();
    logic [31:0] wd [4];
    wd[0] = 32'hA0A0_0001; wd[1] = 32'hB1B1_0002; wd[2] = 32'hC2C2_0003; wd[3] = 32'hD3D3_0004;
    do_reset();
    M0_HBUSREQ = 1'b1; M0_HWRITE = 1'b1; M0_HTRANS = 2'b10; M0_HADDR = 32'h8000_0000;
    M1_HADDR = 32'h5000_0000;
    step();
    total++; if (HTRANS !== 2'b10 || HADDR !== 32'h8000_0000) begin bad++;
      $display("FAIL burst_b1 got trans=%b addr=%h want 10/80000000", HTRANS, HADDR); end
    for (int i = 1; i < 4; i++) begin
      step();
      M0_HADDR = 32'h8000_0000 + 32'(4 * i); M0_HTRANS = 2'b11; M0_HWDATA = wd[i-1];
      if (i == 1) begin M1_HBUSREQ = 1'b1; M1_HTRANS = 2'b10; end
      #1;
      total++; if (HADDR !== 32'h8000_0000 + 32'(4 * i) || HTRANS !== 2'b11) begin bad++;
        $display("FAIL burst_addr beat=%0d got addr=%h trans=%b", i + 1, HADDR, HTRANS); end
      total++; if (HWDATA !== wd[i-1]) begin bad++;
        $display("FAIL burst_wdata beat=%0d got=%h want=%h", i, HWDATA, wd[i-1]); end
      total++; if (M1_HGRANT !== 1'b0 || HMASTER !== 1'b0) begin bad++;
        $display("FAIL burst_split beat=%0d got g1=%b hm=%b want 0/0", i + 1, M1_HGRANT, HMASTER); end
    end
    step();
    M0_HBUSREQ = 1'b0; M0_HTRANS = 2'b00; M0_HWDATA = wd[3];
    #1;
    total++; if (HWDATA !== wd[3]) begin bad++; $display("FAIL burst_wdata beat=4 got=%h want=%h", HWDATA, wd[3]); end
    total++; if (M1_HGRANT !== 1'b0) begin bad++; $display("FAIL burst_b4_g1 got=%b want=0", M1_HGRANT); end
    step();
    total++; if (M1_HGRANT !== 1'b1 || HTRANS !== 2'b00) begin bad++;
      $display("FAIL burst_handover got g1=%b trans=%b want 1/00", M1_HGRANT, HTRANS); end
    step();
    total++; if (HADDR !== 32'h5000_0000 || HTRANS !== 2'b10) begin bad++;
      $display("FAIL burst_m1_own got addr=%h trans=%b want 50000000/10", HADDR, HTRANS); end
  endtask

  task automatic test_starve();
    int first_grant = 0;
    int m1_xfers = 0;
    bit regained = 1'b0;
    do_reset();
    M0_HBUSREQ = 1'b1; M0_HTRANS = 2'b10; M0_HADDR = 32'h0000_0100;
    step();
    M1_HBUSREQ = 1'b1; M1_HTRANS = 2'b10; M1_HADDR = 32'h0000_0200;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (M1_HGRANT === 1'b1 && first_grant == 0) first_grant = k;
      if (HMASTER === 1'b1 && HTRANS === 2'b10 && HADDR === 32'h0000_0200) m1_xfers++;
      if (m1_xfers > 0 && HMASTER === 1'b0) regained = 1'b1;
    end
`ifdef MFP_AHB_ARB_STARVE_EN
    total++; if (first_grant < 5 || first_grant > 6) begin bad++;
      $display("FAIL starve_grant_cycle got=%0d want=5..6", first_grant); end
    total++; if (m1_xfers < 1) begin bad++; $display("FAIL starve_m1_xfer got=%0d want>=1", m1_xfers); end
    total++; if (regained !== 1'b1) begin bad++; $display("FAIL starve_m0_regain got=%b want=1", regained); end
`else
    total++; if (first_grant != 0) begin bad++; $display("FAIL fixed_prio_grant got=%0d want=0 (never)", first_grant); end
    total++; if (m1_xfers != 0) begin bad++; $display("FAIL fixed_prio_xfer got=%0d want=0", m1_xfers); end
`endif
  endtask

  task automatic test_hready_stall();
    do_reset();
    M0_HBUSREQ = 1'b1; M0_HTRANS = 2'b10;
    step();
    M0_HBUSREQ = 1'b0; M0_HTRANS = 2'b00; M0_HWDATA = 32'hAAAA_0000;
    M1_HBUSREQ = 1'b1; M1_HTRANS = 2'b10; M1_HADDR = 32'h0000_0300; M1_HWDATA = 32'hBBBB_0000;
    step();
    HREADY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (M1_HGRANT !== 1'b1 || M0_HGRANT !== 1'b0 || HMASTER !== 1'b1) begin bad++;
        $display("FAIL stall_grant cyc=%0d got g0=%b g1=%b hm=%b", i, M0_HGRANT, M1_HGRANT, HMASTER); end
      total++; if (HTRANS !== 2'b00) begin bad++; $display("FAIL stall_htrans cyc=%0d got=%b want=00", i, HTRANS); end
      total++; if (HWDATA !== 32'hAAAA_0000) begin bad++;
        $display("FAIL stall_hwdata cyc=%0d got=%h want=aaaa0000", i, HWDATA); end
    end
    HREADY = 1'b1;
    step();
    total++; if (HTRANS !== 2'b10 || HADDR !== 32'h0000_0300) begin bad++;
      $display("FAIL stall_release got trans=%b addr=%h want 10/00000300", HTRANS, HADDR); end
    total++; if (HWDATA !== 32'hBBBB_0000) begin bad++; $display("FAIL stall_owner got=%h want=bbbb0000", HWDATA); end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    M1_HBUSREQ = 1'b1; M1_HTRANS = 2'b10; M1_HADDR = 32'h0000_0400;
    step();
    step();
    M1_HTRANS = 2'b11; M1_HADDR = 32'h0000_0404;
    step();
    total++; if (HMASTER !== 1'b1 || HTRANS !== 2'b11) begin bad++;
      $display("FAIL midburst_pre got hm=%b trans=%b want 1/11", HMASTER, HTRANS); end
    #2 HRESETn = 1'b0;
    #1;
    total++; if (M0_HGRANT !== 1'b1 || M1_HGRANT !== 1'b0) begin bad++;
      $display("FAIL midburst_rst_grant got=%b%b want=10", M0_HGRANT, M1_HGRANT); end
    total++; if (HTRANS !== 2'b00 || HMASTER !== 1'b0) begin bad++;
      $display("FAIL midburst_rst_bus got trans=%b hm=%b want 00/0", HTRANS, HMASTER); end
    M1_HBUSREQ = 1'b0;
    @(negedge HCLK);
    HRESETn = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      total++; if (M1_HGRANT !== 1'b0 || HTRANS !== 2'b00) begin bad++;
        $display("FAIL midburst_post cyc=%0d got g1=%b trans=%b want 0/00", i, M1_HGRANT, HTRANS); end
    end
  endtask

  initial begin
    test_reset();
    test_simul_req();
    test_burst();
    test_starve();
    test_hready_stall();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
